// File: rtl/divider_pkg.sv
// Shared types and helpers for the radix-2 restoring divider (divider_iterative).
// The operand width is fixed here by DIV_WIDTH (even, >= 4).
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned CNT_WIDTH = $clog2(DIV_WIDTH);

  typedef logic [DIV_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FIXUP,
    DONE
  } div_state_t;

  typedef struct packed {
    logic  valid;
    word_t quotient;
    word_t remainder;
  } special_t;

  // RISC-V special cases: divide by zero, and most-negative / -1 in signed mode.
  function automatic special_t special_result(logic is_signed, word_t a, word_t b);
    special_t r;
    r = '0;
    if (b == '0) begin
      r.valid     = 1'b1;
      r.quotient  = '1;
      r.remainder = a;
    end else if (is_signed && (a == {1'b1, {(DIV_WIDTH-1){1'b0}}}) && (b == '1)) begin
      r.valid     = 1'b1;
      r.quotient  = a;
      r.remainder = '0;
    end
    return r;
  endfunction

  function automatic word_t negate_if(logic neg, word_t v);
    return neg ? (~v + word_t'(1)) : v;
  endfunction

endpackage

// File: rtl/divider_iterative_if.sv
// Request/response bundle between the issue logic (master) and the divider (slave).
interface divider_iterative_if;
  import divider_pkg::*;

  logic  start;
  logic  is_signed;
  word_t a;
  word_t b;
  word_t quotient;
  word_t remainder;
  logic  done;

  modport master (
    output start, is_signed, a, b,
    input  quotient, remainder, done
  );

  modport slave (
    input  start, is_signed, a, b,
    output quotient, remainder, done
  );

endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference only when it is non-negative.
module divider_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic         dividend_msb_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   rem_o,
  output logic         q_bit_o
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // The extra top bit keeps the trial sign valid when an unsigned divisor has its MSB set.
  assign shifted = {rem_i, dividend_msb_i};
  assign trial   = shifted - {2'b00, divisor_i};

  always_comb begin
    q_bit_o = ~trial[W+1];
    rem_o   = trial[W+1] ? shifted[W:0] : trial[W:0];
  end

endmodule

// File: rtl/divider_iterative.sv
// Radix-2 restoring integer divider with RISC-V signed/unsigned semantics.
// Optional macro DIVIDER_EARLY_OUT_EN: special cases skip the DIVIDE phase.
module divider_iterative
  import divider_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  divider_iterative_if.slave bus
);

  localparam int unsigned W = DIV_WIDTH;

  div_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W:0]           prem_q, prem_d;
  word_t                dvd_q, dvd_d;
  word_t                dvsr_q, dvsr_d;
  word_t                a_q, a_d;
  word_t                b_q, b_d;
  word_t                quot_q, quot_d;
  word_t                rem_q, rem_d;
  logic                 signed_q, signed_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;

  logic       a_neg, b_neg;
  logic [W:0] step_rem;
  logic       step_qbit;
  special_t   lat_special;

  assign a_neg       = bus.is_signed & bus.a[W-1];
  assign b_neg       = bus.is_signed & bus.b[W-1];
  assign lat_special = special_result(signed_q, a_q, b_q);

`ifdef DIVIDER_EARLY_OUT_EN
  special_t in_special;
  assign in_special = special_result(bus.is_signed, bus.a, bus.b);
`endif

  divider_step #(.W(W)) u_step (
    .rem_i          (prem_q),
    .dividend_msb_i (dvd_q[W-1]),
    .divisor_i      (dvsr_q),
    .rem_o          (step_rem),
    .q_bit_o        (step_qbit)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case leaves a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    prem_d   = prem_q;
    dvd_d    = dvd_q;
    dvsr_d   = dvsr_q;
    a_d      = a_q;
    b_d      = b_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          signed_d = bus.is_signed;
          a_d      = bus.a;
          b_d      = bus.b;
          dvd_d    = negate_if(a_neg, bus.a);
          dvsr_d   = negate_if(b_neg, bus.b);
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          prem_d   = '0;
          cnt_d    = CNT_WIDTH'(W - 1);
          state_d  = DIVIDE;
`ifdef DIVIDER_EARLY_OUT_EN
          if (in_special.valid) state_d = FIXUP;
`endif
        end
      end

      DIVIDE: begin
        // The dividend register shifts out its MSB and fills with quotient bits.
        prem_d = step_rem;
        dvd_d  = {dvd_q[W-2:0], step_qbit};
        if (cnt_q == '0) state_d = FIXUP;
        else             cnt_d   = cnt_q - CNT_WIDTH'(1);
      end

      FIXUP: begin
        if (lat_special.valid) begin
          quot_d = lat_special.quotient;
          rem_d  = lat_special.remainder;
        end else begin
          quot_d = negate_if(q_neg_q, dvd_q);
          rem_d  = negate_if(r_neg_q, prem_q[W-1:0]);
        end
        state_d = DONE;
      end

      DONE: begin
        if (!bus.start) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prem_q   <= '0;
      dvd_q    <= '0;
      dvsr_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prem_q   <= prem_d;
      dvd_q    <= dvd_d;
      dvsr_q   <= dvsr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = bus.done ? quot_q : '0;
  assign bus.remainder = bus.done ? rem_q  : '0;

endmodule
